// File: rtl/chain_packet_receiver.sv
// End-of-chain deframer for the ABC serial chip-to-chip link. Received packets
// land in a show-ahead FIFO, and XOFF holds off the last chip while that FIFO
// cannot take another whole packet.
module chain_packet_receiver #(
   parameter int unsigned LOG_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        datIn,
   output logic        xoffOut,
   output logic        pktValid,
   output logic [3:0]  pktId,
   output logic [53:0] pktData,
   input  logic        pktRead,
   output logic        overflow,
   input  logic        overflowClr,
   output logic [7:0]  dropCount,
   output logic        busy
);

   localparam int unsigned DEPTH = 2**LOG_DEPTH;
   localparam int unsigned CW    = LOG_DEPTH + 1;

   typedef enum logic [1:0] {StIdle, StShift, StGuard} state_t;

   state_t      r_state, w_state_next;
   logic [5:0]  r_bit_cnt, w_bit_cnt_next;
   logic [57:0] r_sr, w_sr_next;
   logic        w_offer;

   logic [3:0]           r_mem_id   [DEPTH];
   logic [53:0]          r_mem_data [DEPTH];
   logic [LOG_DEPTH-1:0] r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]        r_count, w_count_next;
   logic                 w_full, w_pop, w_push, w_drop, w_in_flight_next;
   logic [CW:0]          w_occ_next;
   logic                 r_xoff, r_overflow;
   logic [7:0]           r_drop_cnt;

   // Deframer next-state logic
   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_sr_next      = r_sr;
      w_offer        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (datIn) begin
               w_state_next   = StShift;
               w_bit_cnt_next = 6'd58;
            end
         end
         StShift: begin
            w_sr_next      = {r_sr[56:0], datIn};
            w_bit_cnt_next = r_bit_cnt - 6'd1;
            if (r_bit_cnt == 6'd1) begin
               w_state_next = StGuard;
            end
         end
         StGuard: begin
            w_state_next = StIdle;
            w_offer      = 1'b1;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state   <= StIdle;
         r_bit_cnt <= '0;
         r_sr      <= '0;
      end else begin
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_sr      <= w_sr_next;
      end
   end

   assign pktValid = (r_count != '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_pop    = pktRead & pktValid;
   // When full, a same-cycle pop frees the head slot, which is also the write slot
   assign w_push   = w_offer & (~w_full | w_pop);
   assign w_drop   = w_offer & w_full & ~w_pop;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - CW'(1);
      end
   end

   assign w_in_flight_next = (w_state_next != StIdle);
   assign w_occ_next       = (CW + 1)'(w_count_next) + (CW + 1)'(w_in_flight_next);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_id[r_wr_ptr]   <= r_sr[57:54];
         r_mem_data[r_wr_ptr] <= r_sr[53:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_xoff     <= 1'b0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
         end
         r_count <= w_count_next;
         r_xoff  <= (w_occ_next >= (CW + 1)'(DEPTH));
         if (overflowClr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
               r_drop_cnt <= r_drop_cnt + 8'd1;
            end
         end
      end
   end

   assign pktId     = pktValid ? r_mem_id[r_rd_ptr]   : 4'h0;
   assign pktData   = pktValid ? r_mem_data[r_rd_ptr] : 54'h0;
   assign xoffOut   = r_xoff;
   assign overflow  = r_overflow;
   assign dropCount = r_drop_cnt;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_chain_packet_receiver.sv
// Directed bench for chain_packet_receiver: a table of fill packets plus
// hand-written overflow, simultaneous pop/write, reset and continuous-high cases.
module tb_chain_packet_receiver;

   logic        clk = 1'b0;
   logic        rstb;
   logic        datIn;
   logic        xoffOut;
   logic        pktValid;
   logic [3:0]  pktId;
   logic [53:0] pktData;
   logic        pktRead;
   logic        overflow;
   logic        overflowClr;
   logic [7:0]  dropCount;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   chain_packet_receiver #(.LOG_DEPTH(2)) u_dut (
      .clk        (clk),
      .rstb       (rstb),
      .datIn      (datIn),
      .xoffOut    (xoffOut),
      .pktValid   (pktValid),
      .pktId      (pktId),
      .pktData    (pktData),
      .pktRead    (pktRead),
      .overflow   (overflow),
      .overflowClr(overflowClr),
      .dropCount  (dropCount),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  id;
      logic [53:0] data;
      logic        exp_xoff;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pop;
      pktRead = 1'b1;
      tick;
      pktRead = 1'b0;
   endtask

   // One full frame: start edge, 58 data edges, guard edge (optionally with a pop)
   task automatic send(input logic [3:0] id, input logic [53:0] data, input bit chk_xoff,
                       input logic exp_xoff, input bit pop_guard);
      logic [57:0] frame;
      frame = {id, data};
      datIn = 1'b1;
      tick;
      chk("busy_after_start", 64'(busy), 64'd1);
      if (chk_xoff) chk("xoff_at_start", 64'(xoffOut), 64'(exp_xoff));
      for (int i = 57; i >= 0; i--) begin
         datIn = frame[i];
         tick;
      end
      datIn   = 1'b0;
      pktRead = pop_guard;
      tick;
      pktRead = 1'b0;
      chk("busy_after_guard", 64'(busy), 64'd0);
   endtask

   initial begin
      vecs[0] = '{id: 4'h1, data: 54'h00_0000_0000_0001, exp_xoff: 1'b0};
      vecs[1] = '{id: 4'h2, data: 54'h3F_FFFF_FFFF_FFFF, exp_xoff: 1'b0};
      vecs[2] = '{id: 4'h3, data: 54'h15_5555_5555_5555, exp_xoff: 1'b0};
      vecs[3] = '{id: 4'h4, data: 54'h2A_AAAA_AAAA_AAAA, exp_xoff: 1'b1};

      rstb        = 1'b0;
      datIn       = 1'b0;
      pktRead     = 1'b0;
      overflowClr = 1'b0;
      repeat (3) tick;
      chk("rst_pktValid", 64'(pktValid), 64'd0);
      chk("rst_pktId", 64'(pktId), 64'd0);
      chk("rst_pktData", 64'(pktData), 64'd0);
      chk("rst_xoff", 64'(xoffOut), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_dropCount", 64'(dropCount), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rstb = 1'b1;
      repeat (5) tick;

      // Single packet, then pop
      send(4'h5, 54'h2A_BCDE_F012_3456, 1'b1, 1'b0, 1'b0);
      chk("single_valid", 64'(pktValid), 64'd1);
      chk("single_id", 64'(pktId), 64'h5);
      chk("single_data", 64'(pktData), 64'h2A_BCDE_F012_3456);
      repeat (5) tick;
      pop;
      chk("single_popped_valid", 64'(pktValid), 64'd0);
      chk("single_popped_id", 64'(pktId), 64'd0);

      // Back-to-back fill; xoff rises at the 4th start edge
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].id, vecs[i].data, 1'b1, vecs[i].exp_xoff, 1'b0);
         chk("fill_xoff_guard", 64'(xoffOut), 64'(vecs[i].exp_xoff));
      end
      chk("fill_head_id", 64'(pktId), 64'(vecs[0].id));
      chk("fill_head_data", 64'(pktData), 64'(vecs[0].data));
      repeat (3) tick;
      chk("fill_xoff_hold", 64'(xoffOut), 64'd1);

      // Forced 5th packet while full: dropped
      send(4'h7, 54'h12_3456_789A_BCDE, 1'b1, 1'b1, 1'b0);
      chk("drop_overflow", 64'(overflow), 64'd1);
      chk("drop_count", 64'(dropCount), 64'd1);
      chk("drop_head_id", 64'(pktId), 64'(vecs[0].id));
      chk("drop_xoff", 64'(xoffOut), 64'd1);
      overflowClr = 1'b1;
      tick;
      overflowClr = 1'b0;
      chk("clr_overflow", 64'(overflow), 64'd0);
      chk("clr_dropCount", 64'(dropCount), 64'd0);
      chk("clr_valid", 64'(pktValid), 64'd1);

      // Guard edge coincides with a pop while full: both succeed
      send(4'h9, 54'h0F_0F0F_0F0F_0F0F, 1'b1, 1'b1, 1'b1);
      chk("sim_overflow", 64'(overflow), 64'd0);
      chk("sim_dropCount", 64'(dropCount), 64'd0);
      chk("sim_head_id", 64'(pktId), 64'(vecs[1].id));
      chk("sim_head_data", 64'(pktData), 64'(vecs[1].data));
      chk("sim_xoff_full", 64'(xoffOut), 64'd1);
      pop;
      chk("pop_xoff_release", 64'(xoffOut), 64'd0);
      for (int i = 2; i < 4; i++) begin
         chk("drain_id", 64'(pktId), 64'(vecs[i].id));
         chk("drain_data", 64'(pktData), 64'(vecs[i].data));
         pop;
      end
      chk("drain_tail_id", 64'(pktId), 64'h9);
      chk("drain_tail_data", 64'(pktData), 64'h0F_0F0F_0F0F_0F0F);
      pop;
      chk("drain_empty", 64'(pktValid), 64'd0);

      // Reset mid-packet discards the partial frame and FIFO contents
      send(4'h6, 54'h01_2345_6789_ABCD, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_valid", 64'(pktValid), 64'd1);
      datIn = 1'b1;
      tick;
      for (int i = 0; i < 30; i++) begin
         datIn = 1'($urandom_range(0, 1));
         tick;
      end
      rstb  = 1'b0;
      datIn = 1'b0;
      repeat (2) tick;
      rstb = 1'b1;
      tick;
      chk("midrst_valid", 64'(pktValid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_xoff", 64'(xoffOut), 64'd0);
      chk("midrst_id", 64'(pktId), 64'd0);
      send(4'hA, 54'h33_CC33_CC33_CC33, 1'b1, 1'b0, 1'b0);
      chk("postrst_id", 64'(pktId), 64'hA);
      chk("postrst_data", 64'(pktData), 64'h33_CC33_CC33_CC33);
      pop;

      // datIn held high: a guard-time 1 is not a start; frames repeat every 60 edges
      datIn = 1'b1;
      repeat (60) tick;
      chk("high_guard_not_start", 64'(busy), 64'd0);
      chk("high_valid", 64'(pktValid), 64'd1);
      chk("high_id", 64'(pktId), 64'hF);
      chk("high_data", 64'(pktData), 64'h3F_FFFF_FFFF_FFFF);
      repeat (60) tick;
      datIn = 1'b0;
      tick;
      chk("high2_busy", 64'(busy), 64'd0);
      pop;
      chk("high2_id", 64'(pktId), 64'hF);
      chk("high2_data", 64'(pktData), 64'h3F_FFFF_FFFF_FFFF);
      pop;
      chk("high2_empty", 64'(pktValid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/chain_packet_receiver.md
Name: chain_packet_receiver

Overview:
End-of-chain receiver for the ABC chip-to-chip serial data protocol. It sits at the hybrid or readout end of a daisy chain. It deframes the single-wire packets (start bit, 4-bit chip ID, 54-bit payload, guard bit) into a show-ahead packet FIFO. It drives the XOFF back-pressure line so the last chip in the chain holds its transmission when the FIFO cannot accept a complete packet.

Parameters:
LOG_DEPTH, 2, log2 of packet FIFO depth (DEPTH = 2**LOG_DEPTH packets, minimum 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rstb  input  1  synchronous active-low reset, sampled on rising clk
datIn  input  1  serial data from the chain; idle low
xoffOut  output  1  back-pressure to transmitting chip; high = do not start a packet
pktValid  output  1  FIFO head holds a packet
pktId  output  4  chip ID of head packet
pktData  output  54  payload of head packet
pktRead  input  1  pop head packet; ignored when pktValid low
overflow  output  1  sticky: a completed packet was dropped
overflowClr  input  1  clears overflow and dropCount
dropCount  output  8  dropped-packet count, saturates at 255
busy  output  1  deframer is mid-packet

Behaviour:
- Frame on the wire, one bit per clk:
  - Start bit 1.
  - 58 bits MSB first: ID[3:0] then payload[53:0].
  - One guard bit, ignored.
  - Start bit is sampled at edge S, data bits at S+1..S+58, guard at S+59. The earliest next start bit is at S+60.
- Deframer FSM:
  - IDLE: datIn=1 -> SHIFT, bitCounter<=58. datIn=0 stays IDLE.
  - SHIFT: shift datIn into 58-bit SR LSB end, decrement counter. Counter reaching 1 on this shift -> GUARD.
  - GUARD: datIn ignored. Completed SR is offered to the FIFO at this edge. -> IDLE.
- FIFO write at the GUARD edge, outcome depends on state:
  - Not full: write.
  - Full and pktRead&&pktValid in the same cycle: the pop and the write both succeed, count unchanged.
  - Full with no pop: packet dropped, overflow<=1, dropCount increments (saturating at 255).
- FIFO behaviour:
  - Show-ahead: pktId/pktData are valid combinationally from head whenever pktValid=1.
  - pktValid rises the cycle after the GUARD edge when the FIFO was empty (zero extra latency).
  - Pop takes effect at the edge where pktRead&&pktValid.
  - Pointers wrap modulo DEPTH. Count is LOG_DEPTH+1 bits.
- xoffOut is registered, computed from next-state values: xoffOut <= (countNext + inFlightNext) >= DEPTH.
  - inFlightNext = 1 when the next state is SHIFT or GUARD.
  - A packet whose start bit is seen at edge S therefore raises xoffOut at edge S if it consumes the last free slot.
  - The transmitter only samples XOFF while idle, so a started packet always completes.
- busy = (state != IDLE).
- overflowClr: clears overflow and dropCount. If it coincides with a drop, the clear wins over set/increment for overflow, and dropCount<=0.
- Reset values:
  - state IDLE, SR 0, counter 0.
  - FIFO empty: pktValid=0.
  - pktId/pktData=0 when empty.
  - xoffOut=0, overflow=0, dropCount=0, busy=0.
- Reset mid-packet discards the partial packet and all FIFO contents. The first datIn=1 after reset release is treated as a start bit.
- A high datIn in GUARD is not a start bit.
- datIn held high continuously produces back-to-back frames with all-ones content every 60 cycles.

Test Plan:
- Single packet, ID=4'h5, payload=54'h2A_BCDE_F012_3456, start at edge 10 -> pktValid=1 after edge 69, pktId=5, pktData matches; pktRead at edge 75 -> pktValid=0 after 75.
- Back-to-back packets, DEPTH=4, starts at edges 0, 60, 120 with IDs 1, 2, 3, no reads -> 3 packets in order; xoffOut=0 throughout; busy low only at edges 59/60 boundaries as specified.
- Fill: 4 packets, no reads, DEPTH=4 -> xoffOut rises at the 4th start-bit edge and stays 1. One pktRead -> xoffOut=0 the following edge.
- Overflow: FIFO full, 5th packet forced ignoring XOFF, no read -> packet dropped, overflow=1, dropCount=1, FIFO head unchanged. overflowClr pulse -> overflow=0, dropCount=0.
- Simultaneous: FIFO full, 5th packet GUARD edge coincides with pktRead -> head advances, new packet stored at tail, count stays 4, overflow=0.
- Reset mid-packet: rstb=0 at bit 30 of a frame -> after release pktValid=0, busy=0, xoffOut=0. A fresh packet with ID=4'hA is received correctly.
